// File: rtl/conv_cfg_pkg.sv
// Shared field layout, word width and FSM state encoding for the conv config master.
package conv_cfg_pkg;

    localparam int MUL_W   = 5;
    localparam int ACCU_W  = 5;
    localparam int KSH_W   = 6;
    localparam int KCNT_W  = 6;
    localparam int ICNT_W  = 10;
    localparam int OCNT_W  = 10;

    localparam int MUL_LSB   = 0;
    localparam int ACCU_LSB  = 5;
    localparam int KSH_LSB   = 10;
    localparam int KCNT_LSB  = 16;
    localparam int ICNT_LSB  = 22;
    localparam int OCNT_LSB  = 32;
    localparam int VALID_BIT = 42;

    localparam int JOB_W  = 42;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Stored job fields sit at their final offsets, so packing only adds the valid bit.
    function automatic logic [DATA_W-1:0] pack_word(input logic [JOB_W-1:0] job);
        return {{(DATA_W-JOB_W-1){1'b0}}, 1'b1, job};
    endfunction

endpackage

// File: rtl/conv_job_fifo.sv
// Two-entry job FIFO; full/empty come straight from the occupancy count.
module conv_job_fifo
    import conv_cfg_pkg::*;
#(
    parameter int WIDTH = JOB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_cfg_master.sv
// Buffers host jobs, issues each as a packed config word with a start strobe,
// then waits for the accelerator's done pulse or a timeout.
module conv_cfg_master
    import conv_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [MUL_W-1:0]  mul_shift_i,
    input  logic [ACCU_W-1:0] accu_shift_i,
    input  logic [KSH_W-1:0]  kernel_shift_i,
    input  logic [KCNT_W-1:0] kernel_count_i,
    input  logic [ICNT_W-1:0] input_count_i,
    input  logic [OCNT_W-1:0] output_count_i,
    output logic [DATA_W-1:0] data_out,
    output logic              control,
    input  logic              done,
    output logic              busy,
    output logic              job_done,
    output logic              timeout_err,
    output logic              cfg_err,
    output logic [15:0]       jobs_completed
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q;
    logic [15:0]       jobs_q;
    logic              cfg_err_q;

    logic              accept, bad_cfg, push, pop;
    logic              fifo_full, fifo_empty;
    logic [JOB_W-1:0]  fifo_rdata;
    logic              timeout_hit;

    assign accept  = job_valid & job_ready;
    assign bad_cfg = (kernel_count_i == '0) | (input_count_i == '0);
    assign push    = accept & ~bad_cfg;
    assign pop     = (state_q == ST_IDLE) & ~fifo_empty;

    conv_job_fifo #(.WIDTH(JOB_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ({output_count_i, input_count_i, kernel_count_i,
                   kernel_shift_i, accu_shift_i, mul_shift_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            // done takes priority over an expiring timeout
            ST_WAIT: begin
                if (done)             state_d = ST_RESP;
                else if (timeout_hit) state_d = ST_IDLE;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            jobs_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= accept & bad_cfg;
            // Word is latched on the pop so it is already valid during ISSUE
            if (pop)                 data_q <= pack_word(fifo_rdata);
            if (state_q == ST_RESP)  jobs_q <= jobs_q + 16'd1;
        end
    end

    assign job_ready      = ~fifo_full;
    assign data_out       = data_q;
    assign control        = (state_q == ST_ISSUE);
    assign busy           = (state_q != ST_IDLE);
    assign job_done       = (state_q == ST_RESP);
    assign timeout_err    = timeout_hit & ~done;
    assign cfg_err        = cfg_err_q;
    assign jobs_completed = jobs_q;

endmodule
